// File: rtl/tl_ram_responder_if.sv
// A/D channel bundle for a single-beat TileLink-UL link.
// The requester uses the master modport; the terminating RAM uses the slave modport.
interface tl_ram_responder_if;
  // Both channels move one beat on every clock edge where valid & ready are high.
  // valid never waits on ready, and the payload stays stable while valid is high and ready is low.
  logic        io_a_valid;
  logic        io_a_ready;
  logic [2:0]  io_a_bits_opcode;
  logic [2:0]  io_a_bits_param;
  logic [2:0]  io_a_bits_size;
  logic [6:0]  io_a_bits_source;
  logic [31:0] io_a_bits_address;
  logic [7:0]  io_a_bits_mask;
  logic [63:0] io_a_bits_data;
  logic        io_a_bits_corrupt;
  logic        io_d_valid;
  logic        io_d_ready;
  logic [2:0]  io_d_bits_opcode;
  logic [1:0]  io_d_bits_param;
  logic [2:0]  io_d_bits_size;
  logic [6:0]  io_d_bits_source;
  logic        io_d_bits_denied;
  logic [63:0] io_d_bits_data;
  logic        io_d_bits_corrupt;

  modport master (
    output io_a_valid, io_a_bits_opcode, io_a_bits_param, io_a_bits_size,
           io_a_bits_source, io_a_bits_address, io_a_bits_mask, io_a_bits_data,
           io_a_bits_corrupt, io_d_ready,
    input  io_a_ready, io_d_valid, io_d_bits_opcode, io_d_bits_param, io_d_bits_size,
           io_d_bits_source, io_d_bits_denied, io_d_bits_data, io_d_bits_corrupt
  );

  modport slave (
    input  io_a_valid, io_a_bits_opcode, io_a_bits_param, io_a_bits_size,
           io_a_bits_source, io_a_bits_address, io_a_bits_mask, io_a_bits_data,
           io_a_bits_corrupt, io_d_ready,
    output io_a_ready, io_d_valid, io_d_bits_opcode, io_d_bits_param, io_d_bits_size,
           io_d_bits_source, io_d_bits_denied, io_d_bits_data, io_d_bits_corrupt
  );
endinterface

// File: rtl/tl_ram_responder.sv
// Single-beat TileLink-UL slave over a DEPTH x 64-bit register array.
// Responses go through a 2-entry FIFO, so one request per cycle is accepted while D drains.
module tl_ram_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 16
) (
  input logic               clock,
  input logic               reset,
  tl_ram_responder_if.slave bus
);
  localparam int          IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH * 8);

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  size;
    logic [6:0]  source;
    logic        denied;
    logic [63:0] data;
    logic        corrupt;
  } resp_t;

  logic [63:0] r_mem [DEPTH];
  resp_t       r_buf [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic        r_maybe_full;

  logic          w_ptr_match;
  logic          w_full;
  logic          w_empty;
  logic          w_a_fire;
  logic          w_d_fire;
  logic          w_is_get;
  logic          w_is_put;
  logic [2:0]    w_align_mask;
  logic          w_misaligned;
  logic          w_in_range;
  logic          w_denied;
  logic          w_write;
  logic [31:0]   w_offset;
  logic [IW-1:0] w_idx;
  resp_t         w_resp;
  resp_t         w_head;
  logic          w_unused_bits;

  assign w_ptr_match = (r_wr_ptr == r_rd_ptr);
  assign w_full      = w_ptr_match & r_maybe_full;
  assign w_empty     = w_ptr_match & ~r_maybe_full;
  assign w_a_fire    = bus.io_a_valid & ~w_full;
  assign w_d_fire    = ~w_empty & bus.io_d_ready;

  assign w_is_get   = (bus.io_a_bits_opcode == 3'd4);
  assign w_is_put   = (bus.io_a_bits_opcode == 3'd0) | (bus.io_a_bits_opcode == 3'd1);
  assign w_offset   = bus.io_a_bits_address - BASE_ADDR;
  assign w_idx      = w_offset[IW+2:3];
  assign w_in_range = (bus.io_a_bits_address >= BASE_ADDR) &&
                      ({1'b0, bus.io_a_bits_address} < LIMIT);

  // Sizes above 3 are denied on their own, so their mask value never matters.
  always_comb begin
    w_align_mask = 3'b000;
    case (bus.io_a_bits_size)
      3'd1:    w_align_mask = 3'b001;
      3'd2:    w_align_mask = 3'b011;
      3'd3:    w_align_mask = 3'b111;
      default: w_align_mask = 3'b000;
    endcase
  end

  assign w_misaligned = |(bus.io_a_bits_address[2:0] & w_align_mask);
  assign w_denied     = ~(w_is_get | w_is_put) | (bus.io_a_bits_size > 3'd3) | w_misaligned |
                        ~w_in_range | (w_is_put & bus.io_a_bits_corrupt);
  assign w_write      = w_a_fire & w_is_put & ~w_denied;

  always_comb begin
    w_resp         = '0;
    w_resp.opcode  = w_is_get ? 3'd1 : 3'd0;
    w_resp.size    = bus.io_a_bits_size;
    w_resp.source  = bus.io_a_bits_source;
    w_resp.denied  = w_denied;
    w_resp.data    = (w_is_get & ~w_denied) ? r_mem[w_idx] : 64'd0;
    w_resp.corrupt = w_is_get & w_denied;
  end

  // The Get read above samples the array before this edge's write lands.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_write) begin
      for (int b = 0; b < 8; b++) begin
        if (bus.io_a_bits_mask[b]) r_mem[w_idx][8*b +: 8] <= bus.io_a_bits_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_buf[0]     <= '0;
      r_buf[1]     <= '0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_maybe_full <= 1'b0;
    end else begin
      if (w_a_fire) begin
        r_buf[r_wr_ptr] <= w_resp;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_d_fire) r_rd_ptr <= ~r_rd_ptr;
      if (w_a_fire != w_d_fire) r_maybe_full <= w_a_fire;
    end
  end

  assign w_head = r_buf[r_rd_ptr];

  assign bus.io_a_ready        = ~w_full;
  assign bus.io_d_valid        = ~w_empty;
  assign bus.io_d_bits_opcode  = w_head.opcode;
  assign bus.io_d_bits_param   = 2'b00;
  assign bus.io_d_bits_size    = w_head.size;
  assign bus.io_d_bits_source  = w_head.source;
  assign bus.io_d_bits_denied  = w_head.denied;
  assign bus.io_d_bits_data    = w_head.data;
  assign bus.io_d_bits_corrupt = w_head.corrupt;

  assign w_unused_bits = ^{bus.io_a_bits_param, w_offset[31:IW+3], w_offset[2:0]};
endmodule

// File: tb/tb_tl_ram_responder.sv
// Scoreboarded bench for tl_ram_responder: a behavioural RAM model predicts each D beat
// at A acceptance, and a monitor compares beats in order as they leave the DUT.
module tb_tl_ram_responder;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 16;
  localparam int          W     = 81;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  tl_ram_responder_if bus ();

  tl_ram_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [W-1:0] exp_q[$];
  logic [63:0]  model_mem [DEPTH];
  int           n_cmp  = 0;
  int           n_fail = 0;
  logic         rand_mode   = 1'b0;
  logic         d_ready_set = 1'b1;

  // Response layout: {opcode, param, size, source, denied, data, corrupt}
  function automatic logic [W-1:0] model_req(input logic [2:0] op, input logic [2:0] sz,
                                             input logic [6:0] src, input logic [31:0] addr,
                                             input logic [7:0] mask, input logic [63:0] data,
                                             input logic corrupt);
    bit          is_get = (op == 3'd4);
    bit          is_put = (op == 3'd0 || op == 3'd1);
    longint      a      = longint'(addr);
    bit          denied;
    int          idx;
    logic [63:0] rdata  = 64'd0;
    denied = !(is_get || is_put) || (sz > 3) || (a % (longint'(1) << sz) != 0) ||
             (a < longint'(BASE)) || (a >= longint'(BASE) + 8 * DEPTH) || (is_put && corrupt);
    if (!denied) begin
      idx = int'((a - longint'(BASE)) / 8);
      if (is_get) rdata = model_mem[idx];
      else
        for (int b = 0; b < 8; b++)
          if (mask[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
    end
    return {(is_get ? 3'd1 : 3'd0), 2'd0, sz, src, denied, rdata, (is_get && denied)};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Single driver for d_ready, changing just after each rising edge.
  always @(posedge clock) begin
    #1;
    bus.io_d_ready = rand_mode ? ($urandom_range(0, 3) != 0) : d_ready_set;
  end

  // Monitor: a beat fires at the next rising edge whenever valid & ready are high at the falling edge.
  always @(negedge clock) begin
    if (reset && bus.io_d_valid && bus.io_d_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL d_unexpected: got a response with source %0d, expected none", bus.io_d_bits_source);
      end else begin
        check("d_beat", {bus.io_d_bits_opcode, bus.io_d_bits_param, bus.io_d_bits_size,
                         bus.io_d_bits_source, bus.io_d_bits_denied, bus.io_d_bits_data,
                         bus.io_d_bits_corrupt}, exp_q.pop_front());
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance with valid still high.
  task automatic send(input logic [2:0] op, input logic [2:0] sz, input logic [6:0] src,
                      input logic [31:0] addr, input logic [7:0] mask, input logic [63:0] data,
                      input logic corrupt, output int waits);
    bus.io_a_valid        = 1'b1;
    bus.io_a_bits_opcode  = op;
    bus.io_a_bits_param   = 3'($urandom_range(0, 7));
    bus.io_a_bits_size    = sz;
    bus.io_a_bits_source  = src;
    bus.io_a_bits_address = addr;
    bus.io_a_bits_mask    = mask;
    bus.io_a_bits_data    = data;
    bus.io_a_bits_corrupt = corrupt;
    waits = 0;
    while (!bus.io_a_ready && waits < 50) begin
      @(negedge clock);
      waits++;
    end
    if (!bus.io_a_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL a_accept_timeout: a_ready stayed %0b, expected 1", bus.io_a_ready);
      bus.io_a_valid = 1'b0;
      return;
    end
    exp_q.push_back(model_req(op, sz, src, addr, mask, data, corrupt));
    @(negedge clock);
  endtask

  task automatic idle();
    bus.io_a_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clock);
      t++;
    end
    check("drain_empty", W'(exp_q.size()), W'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_d_valid"}, W'(bus.io_d_valid), W'(0));
    check({tag, "_a_ready"}, W'(bus.io_a_ready), W'(1));
    check({tag, "_d_bits"}, {bus.io_d_bits_opcode, bus.io_d_bits_param, bus.io_d_bits_size,
                             bus.io_d_bits_source, bus.io_d_bits_denied, bus.io_d_bits_data,
                             bus.io_d_bits_corrupt}, W'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    logic [2:0]  op;
    logic [2:0]  sz;
    logic [31:0] addr;
    bus.io_a_valid        = 1'b0;
    bus.io_a_bits_opcode  = '0;
    bus.io_a_bits_param   = '0;
    bus.io_a_bits_size    = '0;
    bus.io_a_bits_source  = '0;
    bus.io_a_bits_address = '0;
    bus.io_a_bits_mask    = '0;
    bus.io_a_bits_data    = '0;
    bus.io_a_bits_corrupt = '0;
    bus.io_d_ready        = 1'b1;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clock);

    // Full write then read back, then a partial byte write.
    send(3'd0, 3'd3, 7'd5, BASE + 32'h08, 8'hFF, 64'h1122334455667788, 1'b0, w);
    send(3'd4, 3'd3, 7'd6, BASE + 32'h08, 8'h00, 64'd0, 1'b0, w);
    send(3'd1, 3'd0, 7'd7, BASE + 32'h08, 8'h04, 64'h0000_0000_00AA_0000, 1'b0, w);
    send(3'd4, 3'd3, 7'd8, BASE + 32'h08, 8'h00, 64'd0, 1'b0, w);
    // Denied cases, then confirm the word near the bad Put is untouched.
    send(3'd4, 3'd3, 7'd9, BASE + 32'(8 * DEPTH), 8'hFF, 64'd0, 1'b0, w);
    send(3'd4, 3'd4, 7'd10, BASE + 32'h10, 8'hFF, 64'd0, 1'b0, w);
    send(3'd0, 3'd3, 7'd11, BASE + 32'h04, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, w);
    send(3'd0, 3'd3, 7'd12, BASE + 32'h00, 8'hFF, 64'hCAFE_F00D_CAFE_F00D, 1'b1, w);
    send(3'd4, 3'd3, 7'd13, BASE + 32'h00, 8'h00, 64'd0, 1'b0, w);
    send(3'd4, 3'd3, 7'd14, BASE - 32'h08, 8'h00, 64'd0, 1'b0, w);
    idle();
    drain();

    // Backpressure: two Gets fill the buffer, the third waits for the first D fire.
    d_ready_set = 1'b0;
    @(posedge clock);
    @(negedge clock);
    send(3'd4, 3'd3, 7'd20, BASE + 32'h08, 8'h00, 64'd0, 1'b0, w);
    send(3'd4, 3'd3, 7'd21, BASE + 32'h00, 8'h00, 64'd0, 1'b0, w);
    bus.io_a_bits_source = 7'd22;
    check("bp_a_ready_full", W'(bus.io_a_ready), W'(0));
    @(negedge clock);
    check("bp_a_ready_held", W'(bus.io_a_ready), W'(0));
    d_ready_set = 1'b1;
    @(posedge clock);
    @(negedge clock);
    send(3'd4, 3'd3, 7'd22, BASE + 32'h08, 8'h00, 64'd0, 1'b0, w);
    check("bp_third_wait", W'(w), W'(1));
    idle();
    drain();

    // Back-to-back Put/Get with D always ready: no stalls, response present one edge later.
    for (int i = 0; i < 32; i++) begin
      addr = BASE + 32'($urandom_range(0, DEPTH - 1) * 8);
      if (i % 2 == 0)
        send(3'd0, 3'd3, 7'(i), addr, 8'($urandom), {$urandom, $urandom}, 1'b0, w);
      else
        send(3'd4, 3'd3, 7'(i), addr, 8'h00, 64'd0, 1'b0, w);
      check("burst_no_stall", W'(w), W'(0));
      check("burst_d_valid", W'(bus.io_d_valid), W'(1));
    end
    idle();
    drain();

    // Randomized mix with random D backpressure.
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: op = 3'd4;
        3, 4:    op = 3'd0;
        5:       op = 3'd1;
        default: op = 3'($urandom_range(0, 7));
      endcase
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 8)
        addr = BASE + 32'($urandom_range(0, DEPTH - 1) * 8) + 32'($urandom_range(0, 7));
      else
        addr = BASE + 32'($urandom_range(0, 64 * DEPTH)) - 32'(16 * DEPTH);
      if ($urandom_range(0, 2) != 0 && sz <= 3) addr = addr & ~((32'd1 << sz) - 32'd1);
      send(op, sz, 7'($urandom), addr, 8'($urandom), {$urandom, $urandom},
           ($urandom_range(0, 7) == 0), w);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(negedge clock);
      end
    end
    idle();
    rand_mode = 1'b0;
    drain();

    // Reset with two responses buffered: outputs clear at once, storage reads back zero.
    send(3'd0, 3'd3, 7'd40, BASE + 32'h18, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, w);
    idle();
    d_ready_set = 1'b0;
    @(posedge clock);
    @(negedge clock);
    send(3'd4, 3'd3, 7'd41, BASE + 32'h18, 8'h00, 64'd0, 1'b0, w);
    send(3'd4, 3'd3, 7'd42, BASE + 32'h08, 8'h00, 64'd0, 1'b0, w);
    idle();
    check("pre_reset_full", W'(bus.io_a_ready), W'(0));
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    d_ready_set = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    for (int i = 0; i < DEPTH; i++)
      send(3'd4, 3'd3, 7'(50 + i), BASE + 32'(8 * i), 8'h00, 64'd0, 1'b0, w);
    idle();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
